// File: rtl/v74x139_pkg.sv
// Shared constants and select-to-one-cold mapping for the 74x139 based decoder.
// Pure definitions; no timing or backpressure behaviour of its own.
package v74x139_pkg;

    localparam logic [3:0] Y_INACTIVE = 4'b1111;

    // 0->1110, 1->1101, 2->1011, 3->0111
    function automatic logic [3:0] one_cold(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/v74x139_half.sv
// One 2-to-4 section of a 74x139: active-low enable, active-low outputs.
// Purely combinational (zero latency); no backpressure.
module v74x139_half
    import v74x139_pkg::*;
(
    input  logic       G_L,
    input  logic       A,
    input  logic       B,
    output logic [3:0] Y_L
);

    always_comb begin
        Y_L = Y_INACTIVE;
        if (!G_L) begin
            Y_L = one_cold({B, A});
        end
    end

endmodule

// File: rtl/v74x139_a_decoder.sv
// 3-to-8 active-low decoder from both halves of a 74x139; C selects the bank.
// One cycle latency from sampled A/B/C to registered Y1/Y2; no backpressure.
module v74x139_a_decoder
    import v74x139_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [3:0] Y1,
    output logic [3:0] Y2
);

    logic [3:0] y1_next;
    logic [3:0] y2_next;

    // C enables half 1 directly and half 2 through an inverter, so exactly one bank is live.
    v74x139_half u_half1 (
        .G_L (C),
        .A   (A),
        .B   (B),
        .Y_L (y1_next)
    );

    v74x139_half u_half2 (
        .G_L (~C),
        .A   (A),
        .B   (B),
        .Y_L (y2_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Y1 <= Y_INACTIVE;
            Y2 <= Y_INACTIVE;
        end else begin
            Y1 <= y1_next;
            Y2 <= y2_next;
        end
    end

endmodule

// File: tb/tb_v74x139_a_decoder.sv
// Directed bench for the registered 3-to-8 decoder built from two 74x139 halves.
// Hand-computed expectations; inputs change on the falling edge, outputs sampled 1ns after the rising edge.
module tb_v74x139_a_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       A;
    logic       B;
    logic       C;
    logic [3:0] Y1;
    logic [3:0] Y2;

    int compared   = 0;
    int mismatched = 0;

    v74x139_a_decoder dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .Y1  (Y1),
        .Y2  (Y2)
    );

    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, then return just after the next rising edge.
    task automatic step(input logic r, input logic a, input logic b, input logic c);
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        C   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_tab [4];
        logic [2:0] perm [8];
        logic [7:0] y_all;
        logic [2:0] v;
        logic [2:0] tmp;
        int         zeros;
        int         zidx;
        int         j;

        exp_tab[0] = 4'b1110;
        exp_tab[1] = 4'b1101;
        exp_tab[2] = 4'b1011;
        exp_tab[3] = 4'b0111;

        rst = 1'b1;
        A   = 1'b1;
        B   = 1'b1;
        C   = 1'b1;

        // Reset held for two edges with all selects high
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check4("reset_y1", Y1, 4'b1111);
        check4("reset_y2", Y2, 4'b1111);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        check4("release_y1", Y1, 4'b1110);
        check4("release_y2", Y2, 4'b1111);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, i[0], i[1], 1'b0);
            check4($sformatf("bank1_y1_sel%0d", i), Y1, exp_tab[i]);
            check4($sformatf("bank1_y2_sel%0d", i), Y2, 4'b1111);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, i[0], i[1], 1'b1);
            check4($sformatf("bank2_y1_sel%0d", i), Y1, 4'b1111);
            check4($sformatf("bank2_y2_sel%0d", i), Y2, exp_tab[i]);
        end

        // Mid-cycle input change must not reach the outputs before the next rising edge
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        A = 1'b1;
        B = 1'b1;
        C = 1'b1;
        #1;
        check4("latency_hold_y1", Y1, 4'b1110);
        check4("latency_hold_y2", Y2, 4'b1111);
        @(posedge clk);
        #1;
        check4("latency_upd_y1", Y1, 4'b1111);
        check4("latency_upd_y2", Y2, 4'b0111);

        // Reset in the middle of operation with ABC=101
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check4("run101_y2", Y2, 4'b1101);
        check4("run101_y1", Y1, 4'b1111);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check4("midrst_y1", Y1, 4'b1111);
        check4("midrst_y2", Y2, 4'b1111);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check4("midrst_rel_y1", Y1, 4'b1111);
        check4("midrst_rel_y2", Y2, 4'b1101);

        // Exactly one asserted output over 100 edges; each group of 8 is a shuffled full set
        for (int k = 0; k < 8; k++) perm[k] = k[2:0];
        for (int n = 0; n < 100; n++) begin
            if (n % 8 == 0) begin
                for (int k = 7; k > 0; k--) begin
                    j       = $urandom_range(k, 0);
                    tmp     = perm[k];
                    perm[k] = perm[j];
                    perm[j] = tmp;
                end
            end
            v = perm[n % 8];
            step(1'b0, v[0], v[1], v[2]);
            y_all = ~{Y2, Y1};
            zeros = 0;
            zidx  = -1;
            for (int b = 0; b < 8; b++) begin
                if (y_all[b] === 1'b1) begin
                    zeros++;
                    zidx = b;
                end
            end
            check_int($sformatf("onehot_count_n%0d", n), zeros, 1);
            check_int($sformatf("onehot_index_n%0d", n), zidx, int'(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/v74x139_a_decoder.md
Name: v74x139_a_decoder

Overview:
- 3-to-8 line decoder built from the two halves of a 74x139 dual 2-to-4 decoder.
- Outputs are active-low.
- C is the bank select, routed to the active-low enable of half 1 and, inverted, to the enable of half 2.
- A is the select LSB and B is the select MSB.
- Outputs are registered on the single system clock. Used as a small address/chip-select decoder.

Parameters:
- none (widths fixed: 3 select inputs, two 4-bit output banks)

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  1  select bit 0 (LSB).
- B  input  1  select bit 1.
- C  input  1  bank select: 0 enables bank Y1, 1 enables bank Y2.
- Y1  output  4  active-low decoded outputs, bank 1 (C=0).
- Y2  output  4  active-low decoded outputs, bank 2 (C=1).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on any rising clk edge with rst=1, Y1=4'b1111 and Y2=4'b1111 (all inactive). rst has priority over inputs.
- Decode function, with sel = {B,A} (0..3):
  - C=0: Y1 = all ones except bit sel = 0; Y2 = 4'b1111.
  - C=1: Y2 = all ones except bit sel = 0; Y1 = 4'b1111.
- Exactly one of the 8 output bits is 0 at any time after the first non-reset edge; never zero or two asserted.
- Latency: inputs sampled at rising edge N; Y1/Y2 reflect them after edge N and hold until the next edge.
- No combinational path from A/B/C to Y1/Y2.
- Input changes between edges are ignored; only the value at the sampling edge matters.
- Reset mid-operation: the next edge with rst=1 forces all-ones regardless of A/B/C. The first edge with rst=0 loads the decoded value of the current inputs.
- Before the first clock edge, output values are undefined. The bench must apply reset first.
- X/Z on inputs is not handled; the bench drives only 0/1.

Decomposition:
- Shared package v74x139_pkg:
  - localparam Y_INACTIVE = 4'b1111.
  - function or constant mapping a 2-bit select to a one-cold 4-bit pattern (0→1110, 1→1101, 2→1011, 3→0111).
- Sub-module v74x139_half: combinational 2-to-4 decoder, one 74x139 section.
  - Ports: G_L (active-low enable), A, B, Y_L[3:0].
  - Y_L = one-cold(sel) when G_L=0, else 4'b1111.
- Top instantiates two halves:
  - Half 1: G_L=C, A, B.
  - Half 2: G_L=~C, A, B.
  - Both results registered into Y1/Y2 with synchronous reset.

Test Plan:
- Reset: rst=1 for 2 edges with A=B=C=1 → Y1=1111, Y2=1111. Deassert with ABC=000 → next edge Y1=1110, Y2=1111.
- Bank 1 sweep, C=0, (A,B) = (0,0),(1,0),(0,1),(1,1) one per edge → Y1 = 1110, 1101, 1011, 0111; Y2=1111 throughout.
- Bank 2 sweep, C=1, same (A,B) order → Y2 = 1110, 1101, 1011, 0111; Y1=1111 throughout.
- Latency: change ABC 000→111 mid-cycle → Y unchanged until next rising edge, then Y2=0111, Y1=1111.
- Reset mid-operation: ABC=101 running (Y2=1101), assert rst one edge → both 1111. Release → Y2=1101 on the following edge.
- Invariant check, all 8 combinations in random order over 100 edges → popcount of ~{Y2,Y1} is exactly 1 and its index equals {C,B,A}.
